// File: rtl/fpga_robots_game_keysrc_arb_if.sv
// Keycode source bundle: two byte-wide strobed keycode inputs (PS/2 and
// serial) and the merged, paced keycode stream with its status pulses.
// i_* signals flow into the arbiter, o_* signals flow out of it.
interface fpga_robots_game_keysrc_arb_if;
    logic [7:0] i_ps2_kc_dat;
    logic       i_ps2_kc_stb;
    logic [7:0] i_ser_kc_dat;
    logic       i_ser_kc_stb;
    logic [7:0] o_kc_dat;
    logic       o_kc_stb;
    logic       o_kc_src;
    logic       o_ovf_ps2;
    logic       o_ovf_ser;
    logic       o_lock_drop;

    // Keycode producers (and the bench) drive the inputs, observe the stream.
    modport master (
        output i_ps2_kc_dat, i_ps2_kc_stb, i_ser_kc_dat, i_ser_kc_stb,
        input  o_kc_dat, o_kc_stb, o_kc_src, o_ovf_ps2, o_ovf_ser, o_lock_drop
    );

    // The arbiter consumes the inputs and produces the merged stream.
    modport slave (
        input  i_ps2_kc_dat, i_ps2_kc_stb, i_ser_kc_dat, i_ser_kc_stb,
        output o_kc_dat, o_kc_stb, o_kc_src, o_ovf_ps2, o_ovf_ser, o_lock_drop
    );
endinterface

// File: rtl/fpga_robots_game_keysrc_arb.sv
// Keycode source arbiter: queues PS/2 and serial keycode bytes in small
// per-source FIFOs, grants them round-robin at a paced rate, and keeps an
// E0/F0 prefix together with the byte(s) that complete it. A lock whose
// source goes quiet is released after LOCK_TO cycles.
// Source index 0 is PS/2, index 1 is serial, everywhere in this file.
module fpga_robots_game_keysrc_arb #(
    parameter int FIFO_AW = 2,
    parameter int GAP     = 2,
    parameter int LOCK_TO = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    fpga_robots_game_keysrc_arb_if.slave  bus
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int TO_W  = $clog2(LOCK_TO + 1);
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [7:0] KC_EXT = 8'hE0;
    localparam logic [7:0] KC_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOCK_PS2,
        ST_LOCK_SER
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TO_W-1:0]    r_to;
    logic [TO_W-1:0]    w_to_nxt;
    logic [GAP_W-1:0]   r_gap;
    logic               r_rr;

    logic [7:0]         r_mem [2][DEPTH];
    logic [FIFO_AW-1:0] r_wp  [2];
    logic [FIFO_AW-1:0] r_rp  [2];
    logic [FIFO_AW:0]   r_cnt [2];

    logic [7:0]         w_in_dat [2];
    logic [1:0]         w_in_stb;
    logic [1:0]         w_empty;
    logic [1:0]         w_full;
    logic [1:0]         w_rd;
    logic [1:0]         w_wr;
    logic [1:0]         w_drop;

    logic               w_gnt_vld;
    logic               w_gnt_src;
    logic [7:0]         w_gnt_dat;
    logic               w_gnt_prefix;
    logic               w_lock_src;
    logic               w_lock_drop;

    logic [7:0]         r_kc_dat;
    logic               r_kc_stb;
    logic               r_kc_src;
    logic [1:0]         r_ovf;
    logic               r_lock_drop;

    // Put both sources into indexable form and derive FIFO status and
    // write/drop decisions; a read on a full FIFO frees the slot for a
    // same-cycle write.
    always_comb begin
        w_in_stb    = {bus.i_ser_kc_stb, bus.i_ps2_kc_stb};
        w_in_dat[0] = bus.i_ps2_kc_dat;
        w_in_dat[1] = bus.i_ser_kc_dat;
        w_rd        = w_gnt_vld ? (w_gnt_src ? 2'b10 : 2'b01) : 2'b00;
        for (int i = 0; i < 2; i++) begin
            w_empty[i] = (r_cnt[i] == '0);
            w_full[i]  = (r_cnt[i] == FULL_CNT);
            w_wr[i]    = w_in_stb[i] && (!w_full[i] || w_rd[i]);
            w_drop[i]  = w_in_stb[i] && w_full[i] && !w_rd[i];
        end
    end

    // Grant selection: paced by the gap counter, restricted to the locked
    // source while a prefix sequence is open, round-robin otherwise.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        w_gnt_vld = 1'b0;
        w_gnt_src = 1'b0;
        if (r_gap == '0) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty[0] && !w_empty[1]) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_src = r_rr;
                    end else if (!w_empty[0]) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_src = 1'b0;
                    end else if (!w_empty[1]) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_src = 1'b1;
                    end
                end
                ST_LOCK_PS2: begin
                    w_gnt_vld = !w_empty[0];
                    w_gnt_src = 1'b0;
                end
                ST_LOCK_SER: begin
                    w_gnt_vld = !w_empty[1];
                    w_gnt_src = 1'b1;
                end
                default: ;
            endcase
        end
        w_gnt_dat    = r_mem[w_gnt_src][r_rp[w_gnt_src]];
        w_gnt_prefix = (w_gnt_dat == KC_EXT) || (w_gnt_dat == KC_BRK);
    end

    // Next state: a granted prefix opens (or keeps) its source's lock, any
    // other granted byte closes it; a lock idling on an empty FIFO times out.
    always_comb begin
        w_state_nxt = r_state;
        w_to_nxt    = r_to;
        w_lock_drop = 1'b0;
        w_lock_src  = (r_state == ST_LOCK_SER);
        if (w_gnt_vld) begin
            w_to_nxt = '0;
            if (w_gnt_prefix) begin
                w_state_nxt = w_gnt_src ? ST_LOCK_SER : ST_LOCK_PS2;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end else if (r_state != ST_IDLE && w_empty[w_lock_src]) begin
            if (r_to == TO_W'(LOCK_TO - 1)) begin
                w_state_nxt = ST_IDLE;
                w_to_nxt    = '0;
                w_lock_drop = 1'b1;
            end else begin
                w_to_nxt = r_to + TO_W'(1);
            end
        end
    end

    // State and lock-timeout registers.
    always_ff @(posedge clk) begin
        // NOTE: registers are assigned with <= so every flop samples the
        // pre-edge values regardless of statement order.
        if (rst) begin
            r_state <= ST_IDLE;
            r_to    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_to    <= w_to_nxt;
        end
    end

    // FIFO storage writes.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; emptiness is tracked by the
        // pointers and counts, so flushing them is enough and the array can
        // map onto distributed RAM.
        for (int i = 0; i < 2; i++) begin
            if (w_wr[i]) begin
                r_mem[i][r_wp[i]] <= w_in_dat[i];
            end
        end
    end

    // FIFO pointers and occupancy; reset flushes both queues.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                r_wp[i]  <= '0;
                r_rp[i]  <= '0;
                r_cnt[i] <= '0;
            end else begin
                if (w_wr[i]) r_wp[i] <= r_wp[i] + FIFO_AW'(1);
                if (w_rd[i]) r_rp[i] <= r_rp[i] + FIFO_AW'(1);
                if (w_wr[i] && !w_rd[i]) begin
                    r_cnt[i] <= r_cnt[i] + (FIFO_AW + 1)'(1);
                end else if (w_rd[i] && !w_wr[i]) begin
                    r_cnt[i] <= r_cnt[i] - (FIFO_AW + 1)'(1);
                end
            end
        end
    end

    // Pacing gap, round-robin pointer and registered output stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap       <= '0;
            r_rr        <= 1'b0;
            r_kc_dat    <= '0;
            r_kc_stb    <= 1'b0;
            r_kc_src    <= 1'b0;
            r_ovf       <= '0;
            r_lock_drop <= 1'b0;
        end else begin
            r_kc_stb    <= w_gnt_vld;
            r_ovf       <= w_drop;
            r_lock_drop <= w_lock_drop;
            if (w_gnt_vld) begin
                r_gap    <= GAP_W'(GAP);
                r_rr     <= ~w_gnt_src;
                r_kc_dat <= w_gnt_dat;
                r_kc_src <= w_gnt_src;
            end else if (r_gap != '0) begin
                r_gap <= r_gap - GAP_W'(1);
            end
        end
    end

    assign bus.o_kc_dat    = r_kc_dat;
    assign bus.o_kc_stb    = r_kc_stb;
    assign bus.o_kc_src    = r_kc_src;
    assign bus.o_ovf_ps2   = r_ovf[0];
    assign bus.o_ovf_ser   = r_ovf[1];
    assign bus.o_lock_drop = r_lock_drop;
endmodule
